volume_history_meter: RTL and testbench

- Scrolling, parametrised successor to the static 16-level volume bar display.
- Keeps a history of NUM_COLS smoothed volume samples, newest column at the right edge.
- Applies attack/decay smoothing and tracks an optional peak-hold level.
- Renders each queried OLED pixel (x,y) into an RGB565 colour with a registered 1-cycle pixel pipeline; sits between the mic-volume extractor and the OLED driver mux.

---
 rtl/volume_history_meter.sv | 175 +++++++++++++++++
 tb/tb_volume_history_meter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/volume_history_meter.sv
// Scrolling volume history bar graph. It smooths the level with an attack/decay rule and renders RGB565 pixels with one cycle of latency.
// Optional peak-hold marker: define VOLUME_METER_PEAK_HOLD_EN.
module volume_history_meter #(
  parameter int          NUM_LEVELS   = 16,
  parameter int          NUM_COLS     = 16,
  parameter int          BAR_X0       = 43,
  parameter int          BAR_W        = 2,
  parameter int          BAR_PITCH    = 3,
  parameter int          BASE_Y       = 52,
  parameter int          SEG_H        = 2,
  parameter int          SEG_PITCH    = 3,
  parameter int          DECAY_STEP   = 1,
  parameter int          HOLD_SAMPLES = 8,
  parameter logic [15:0] UNLIT_COLOUR = 16'hC618,
  parameter logic [15:0] PEAK_COLOUR  = 16'h0000,
  parameter int          LW           = $clog2(NUM_LEVELS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sample_strobe,
  input  logic [LW-1:0] level_in,
  input  logic          freeze,
  input  logic [6:0]    x,
  input  logic [5:0]    y,
  output logic [15:0]   oled_data,
  output logic [LW-1:0] cur_level,
  output logic [LW-1:0] peak_level
);

  function automatic logic [15:0] band_colour(input int band);
    case (band)
      0:       return 16'h8204;
      1:       return 16'hF800;
      2:       return 16'hFC00;
      3:       return 16'hFFE0;
      4:       return 16'h07E0;
      5:       return 16'h5FFF;
      6:       return 16'h001F;
      default: return 16'hF81F;
    endcase
  endfunction

  logic [LW-1:0] history_reg [NUM_COLS];
  logic [LW-1:0] cur_reg;
  logic [LW-1:0] in_sat;
  logic [LW-1:0] decayed;
  logic [LW-1:0] new_s;
  logic          accept;
  logic [15:0]   oled_data_reg;
  logic [15:0]   pixel_next;

  assign accept = sample_strobe & ~freeze;

  // Attack is instant; decay is rate-limited and clamps at zero.
  always_comb begin
    in_sat  = (level_in > LW'(NUM_LEVELS)) ? LW'(NUM_LEVELS) : level_in;
    decayed = (cur_reg > LW'(DECAY_STEP)) ? cur_reg - LW'(DECAY_STEP) : '0;
    if (in_sat >= cur_reg)
      new_s = in_sat;
    else
      new_s = (in_sat > decayed) ? in_sat : decayed;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_reg <= '0;
      for (int i = 0; i < NUM_COLS; i++)
        history_reg[i] <= '0;
    end else if (accept) begin
      cur_reg <= new_s;
      for (int i = 0; i < NUM_COLS - 1; i++)
        history_reg[i] <= history_reg[i+1];
      history_reg[NUM_COLS-1] <= new_s;
    end
  end

  assign cur_level = cur_reg;

`ifdef VOLUME_METER_PEAK_HOLD_EN
  localparam int HW = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;
  logic [LW-1:0] peak_reg;
  logic [HW-1:0] hold_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      peak_reg <= '0;
      hold_reg <= '0;
    end else if (accept) begin
      if (new_s >= peak_reg) begin
        peak_reg <= new_s;
        hold_reg <= HW'(HOLD_SAMPLES);
      end else if (hold_reg != '0) begin
        hold_reg <= hold_reg - 1'b1;
      end else begin
        // new_s < peak_reg here, so peak_reg is at least 1.
        peak_reg <= ((peak_reg - 1'b1) > new_s) ? peak_reg - 1'b1 : new_s;
      end
    end
  end

  assign peak_level = peak_reg;
`else
  assign peak_level = '0;
`endif

  // Column/segment hit detection. Signed compare so negative extents never match.
  logic signed [15:0]   x_s;
  logic signed [15:0]   y_s;
  logic [NUM_COLS-1:0]  col_hit;
  logic [NUM_LEVELS-1:0] seg_hit;
  logic [15:0]          seg_colour [NUM_LEVELS];

  assign x_s = {9'd0, x};
  assign y_s = {10'd0, y};

  generate
    for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
      localparam int XL = BAR_X0 + gi * BAR_PITCH;
      localparam int XH = XL + BAR_W - 1;
      assign col_hit[gi] = (x_s >= $signed(16'(XL))) && (x_s <= $signed(16'(XH)));
    end
    for (genvar gi = 0; gi < NUM_LEVELS; gi++) begin : g_seg
      localparam int YB = BASE_Y - gi * SEG_PITCH;
      localparam int YT = YB - SEG_H + 1;
      assign seg_hit[gi]    = (y_s >= $signed(16'(YT))) && (y_s <= $signed(16'(YB)));
      assign seg_colour[gi] = band_colour((gi * 8) / NUM_LEVELS);
    end
  endgenerate

  logic [LW-1:0] sel_level;
  logic [LW-1:0] seg_idx;
  logic [15:0]   band_sel;
  logic          in_seg;
  logic          lit;
  logic          peak_mark;

  always_comb begin
    sel_level = '0;
    seg_idx   = '0;
    band_sel  = 16'hFFFF;
    for (int i = 0; i < NUM_COLS; i++)
      if (col_hit[i]) sel_level = history_reg[i];
    for (int i = 0; i < NUM_LEVELS; i++)
      if (seg_hit[i]) begin
        seg_idx  = LW'(i);
        band_sel = seg_colour[i];
      end
    in_seg = (|col_hit) && (|seg_hit);
    lit    = in_seg && (seg_idx < sel_level);
`ifdef VOLUME_METER_PEAK_HOLD_EN
    peak_mark = in_seg && (peak_reg != '0) && (seg_idx == peak_reg - 1'b1) &&
                (seg_idx >= sel_level);
`else
    peak_mark = 1'b0;
`endif
    if (lit)
      pixel_next = band_sel;
    else if (peak_mark)
      pixel_next = PEAK_COLOUR;
    else if (in_seg)
      pixel_next = UNLIT_COLOUR;
    else
      pixel_next = 16'hFFFF;
  end

  always_ff @(posedge clk) begin
    if (rst)
      oled_data_reg <= 16'hFFFF;
    else
      oled_data_reg <= pixel_next;
  end

  assign oled_data = oled_data_reg;

endmodule

// File: tb/tb_volume_history_meter.sv
// Randomised and directed bench for volume_history_meter against a behavioural model
// of history, smoothing, peak hold and pixel geometry.
module tb_volume_history_meter;

  localparam int NL = 16, NC = 16, LW = 5;
  localparam int X0 = 43, BW = 2, BP = 3, BY = 52, SH = 2, SP = 3;
  localparam int DECAY = 1, HOLD = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_strobe = 1'b0;
  logic [LW-1:0] level_in = '0;
  logic          freeze = 1'b0;
  logic [6:0]    x = '0;
  logic [5:0]    y = '0;
  logic [15:0]   oled_data;
  logic [LW-1:0] cur_level;
  logic [LW-1:0] peak_level;

  volume_history_meter dut (
    .clk(clk), .rst(rst), .sample_strobe(sample_strobe), .level_in(level_in),
    .freeze(freeze), .x(x), .y(y), .oled_data(oled_data),
    .cur_level(cur_level), .peak_level(peak_level)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int m_hist [NC];
  int m_cur, m_peak, m_hold;
  logic [15:0] band_tab [8] = '{16'h8204, 16'hF800, 16'hFC00, 16'hFFE0,
                                16'h07E0, 16'h5FFF, 16'h001F, 16'hF81F};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NC; c++) m_hist[c] = 0;
    m_cur = 0; m_peak = 0; m_hold = 0;
  endfunction

  function automatic void model_accept(input int lv);
    int inl, ns;
    inl = (lv > NL) ? NL : lv;
    if (inl >= m_cur) ns = inl;
    else begin
      ns = m_cur - DECAY;
      if (ns < 0) ns = 0;
      if (inl > ns) ns = inl;
    end
    for (int c = 0; c < NC - 1; c++) m_hist[c] = m_hist[c+1];
    m_hist[NC-1] = ns;
    m_cur = ns;
`ifdef VOLUME_METER_PEAK_HOLD_EN
    if (ns >= m_peak) begin m_peak = ns; m_hold = HOLD; end
    else if (m_hold != 0) m_hold--;
    else m_peak = (m_peak - 1 > ns) ? m_peak - 1 : ns;
`endif
  endfunction

  function automatic logic [15:0] model_pix(input int px, input int py);
    bit lit = 0, pk = 0, any = 0;
    logic [15:0] col = 16'hFFFF;
    for (int c = 0; c < NC; c++) begin
      if (px < X0 + c*BP || px > X0 + c*BP + BW - 1) continue;
      for (int s = 0; s < NL; s++) begin
        if (py < BY - s*SP - SH + 1 || py > BY - s*SP) continue;
        any = 1;
        if (s < m_hist[c]) begin lit = 1; col = band_tab[(s*8)/NL]; end
        else if (m_peak > 0 && s == m_peak - 1) pk = 1;
      end
    end
    if (lit) return col;
    if (pk) return 16'h0000;
    if (any) return 16'hC618;
    return 16'hFFFF;
  endfunction

  // One clock: drive, predict from pre-edge state, advance model, compare.
  task automatic cycle(input bit stb, input int lv, input bit frz, input int px, input int py);
    logic [15:0] exp_pix;
    sample_strobe = stb; level_in = LW'(lv); freeze = frz; x = 7'(px); y = 6'(py);
    exp_pix = model_pix(px, py);
    @(posedge clk); #1;
    if (stb && !frz) model_accept(lv);
    sample_strobe = 1'b0;
    check("pixel", oled_data, exp_pix);
    check("cur_level", 16'(cur_level), 16'(m_cur));
    check("peak_level", 16'(peak_level), 16'(m_peak));
  endtask

  initial begin
    // Reset held for two cycles with a competing strobe.
    rst = 1'b1; sample_strobe = 1'b1; level_in = 5'd16;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; sample_strobe = 1'b0;
    model_reset();
    check("rst_oled", oled_data, 16'hFFFF);
    check("rst_cur", 16'(cur_level), 16'd0);
    check("rst_peak", 16'(peak_level), 16'd0);
    cycle(0, 0, 0, 88, 6);  check("rst_q88_6", oled_data, 16'hC618);
    cycle(0, 0, 0, 0, 0);   check("rst_q0_0", oled_data, 16'hFFFF);

    // Step up; the same-cycle query sees pre-strobe history.
    cycle(1, 16, 0, 88, 6); check("pre_strobe", oled_data, 16'hC618);
    check("step_cur", 16'(cur_level), 16'd16);
    cycle(0, 0, 0, 88, 6);  check("step_q88_6", oled_data, 16'hF81F);
    cycle(0, 0, 0, 88, 52); check("step_q88_52", oled_data, 16'h8204);
    cycle(0, 0, 0, 85, 6);

    // Saturation and decay.
    cycle(1, 20, 0, 0, 0); check("sat_cur", 16'(cur_level), 16'd16);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 88, 13);
    check("decay_cur", 16'(cur_level), 16'd13);
    cycle(0, 0, 0, 88, 13); cycle(0, 0, 0, 85, 10);

    // Scroll.
    for (int i = 0; i < 16; i++) cycle(1, 4, 0, 43 + 3*i, 43);
    cycle(1, 0, 0, 43, 43);
    cycle(0, 0, 0, 43, 43);
    for (int i = 0; i < 16; i++) cycle(1, 0, 0, 43 + 3*i, 52);
    for (int i = 0; i < 16; i++) cycle(0, 0, 0, 43 + 3*i, 52 - 3*i);

    // Freeze.
    cycle(1, 10, 0, 0, 0); check("frz_cur0", 16'(cur_level), 16'd10);
    for (int i = 0; i < 5; i++) cycle(1, 0, 1, 88, 25);
    check("frz_hold", 16'(cur_level), 16'd10);
    cycle(1, 0, 0, 88, 25); check("frz_release", 16'(cur_level), 16'd9);

    // Peak hold sequence (peak_level is 0 throughout without the feature).
    cycle(1, 12, 0, 43, 19);
    for (int i = 0; i < 14; i++) cycle(1, 0, 0, 43, 19);
    cycle(0, 0, 0, 43, 19);

    // Randomised traffic, weighted towards the bar area.
    for (int i = 0; i < 1500; i++) begin
      int lv, px, py;
      bit stb, frz;
      stb = ($urandom_range(0, 2) != 0);
      frz = ($urandom_range(0, 7) == 0);
      lv  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 16);
      px  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 127) : $urandom_range(40, 95);
      py  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 55);
      cycle(stb, lv, frz, px, py);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
